multicycle_ctrl: RTL



---
 rtl/ctrl_pkg.sv | 19 +
 rtl/wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and decode helpers for the multi-cycle RV32 sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID_EX = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Stores, branches and fences produce no register result.
  function automatic logic rf_wr_allowed(input logic store, input logic branch,
                                         input logic fence);
    return !(store | branch | fence);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts unanswered request cycles and flags a bus timeout on the last allowed one.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (active && !ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // A ready in the final allowed cycle suppresses the timeout.
  assign timeout = (TIMEOUT > 0) && active && !ready &&
                   (wait_cnt == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer with ready handshakes, bus timeout and halt.
//   state | meaning
//   IF    | fetch, wait for imem_ready
//   ID_EX | decode/execute, fast retire of non-memory ops when FAST_WB
//   MEM   | data access, wait for dmem_ready
//   WB    | retire: PC and register-file write
//   HALT  | parked until resume
//   ERR   | bus timeout, sticky until reset
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int FAST_WB = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             store,
  input  logic             branch,
  input  logic             fence,
  input  logic             halt,
  input  logic [3:0]       decoder_dmem_we,
  input  logic             resume,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_rd,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             dmem_rd,
  output logic [3:0]       dmem_we,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state, state_nxt;
  logic   retire;
  logic   timeout;
  logic   req_active;
  logic   req_ready;
  logic   mem_op;

  assign mem_op = load | store;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: begin
        if (imem_ready)   state_nxt = S_ID_EX;
        else if (timeout) state_nxt = S_ERR;
      end
      S_ID_EX: begin
        if (halt)              state_nxt = S_HALT;
        else if (mem_op)       state_nxt = S_MEM;
        else if (FAST_WB != 0) state_nxt = S_IF;
        else                   state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_op && dmem_ready) state_nxt = S_WB;
        else if (timeout)         state_nxt = S_ERR;
      end
      S_WB:    state_nxt = S_IF;
      S_HALT:  if (resume) state_nxt = S_IF;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IF;
    endcase
  end

  always_comb begin
    imem_rd = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    dmem_rd = 1'b0;
    dmem_we = 4'b0000;
    halted  = 1'b0;
    error   = 1'b0;
    retire  = 1'b0;
    if (rstn) begin
      case (state)
        S_IF: begin
          imem_rd = 1'b1;
          ir_we   = imem_ready;
        end
        S_ID_EX: begin
          if (!halt && !mem_op && (FAST_WB != 0)) begin
            pc_we  = 1'b1;
            rf_we  = rf_wr_allowed(store, branch, fence);
            retire = 1'b1;
          end
        end
        S_MEM: begin
          dmem_rd = load;
          dmem_we = store ? decoder_dmem_we : 4'b0000;
        end
        S_WB: begin
          pc_we  = 1'b1;
          rf_we  = rf_wr_allowed(store, branch, fence);
          retire = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
          pc_we  = resume;
        end
        S_ERR:   error = 1'b1;
        default: ;
      endcase
    end
  end

  // Only an outstanding request can time out; ready elsewhere is ignored.
  assign req_active = rstn && ((state == S_IF) || ((state == S_MEM) && mem_op));
  assign req_ready  = (state == S_IF) ? imem_ready : dmem_ready;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (state_nxt != state),
    .active  (req_active),
    .ready   (req_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT && state != S_ERR) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
